// File: rtl/bin_bcd_seq_if.sv
// Start/busy/done handshake bundle for the sequential binary-to-BCD converter.
// Carries the optional blank vector when BIN_BCD_SEQ_LZB_EN is defined.
interface bin_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN_BCD_SEQ_LZB_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, output bin, input busy, input done, input bcd, input blank);
  modport slave  (input start, input bin, output busy, output done, output bcd, output blank);
`else
  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
`endif
endinterface

// File: rtl/bin_bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking output is enabled by defining BIN_BCD_SEQ_LZB_EN.
module bin_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  bin_bcd_seq_if.slave    bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   binreg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   adj;
  logic [CNT_W-1:0]   count;
  logic [SCR_W-1:0]   bcd_r;
  logic               busy_r;
  logic               done_r;

  // Add-3 correction on every digit before the shift; no carry between digits.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

`ifdef BIN_BCD_SEQ_LZB_EN
  logic [DIGITS-1:0]  blank_r;
  logic [DIGITS-1:0]  blank_next;
  logic               zero_run;

  // Digit 0 always shows, so a zero result still displays a single "0".
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (scratch[4*i +: 4] == 4'd0);
      blank_next[i] = zero_run;
    end
  end

  assign bus.blank = blank_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      binreg  <= '0;
      scratch <= '0;
      count   <= '0;
      bcd_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef BIN_BCD_SEQ_LZB_EN
      blank_r <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          if (bus.start) begin
            binreg  <= bus.bin;
            scratch <= '0;
            count   <= CNT_W'(BIN_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          busy_r  <= 1'b1;
          // Bits leaving the top digit are dropped: this is the truncation case.
          scratch <= SCR_W'({adj, binreg[BIN_W-1]});
          binreg  <= binreg << 1;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd_r   <= scratch;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
`ifdef BIN_BCD_SEQ_LZB_EN
          blank_r <= blank_next;
`endif
          state   <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq: three instances (8/3, 4/2, 10/4) with a
// cycle-level behavioural model and per-cycle compare on the 8-bit instance.
`timescale 1ns/1ps
module tb_bin_bcd_seq;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 0;

  bin_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) bus_a ();
  bin_bcd_seq_if #(.BIN_W(4),  .DIGITS(2)) bus_b ();
  bin_bcd_seq_if #(.BIN_W(10), .DIGITS(4)) bus_c ();

  bin_bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bin_bcd_seq #(.BIN_W(4),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  bin_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by plain division; upper digits beyond 'digits' are dropped.
  function automatic logic [63:0] ref_bcd(input longint v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r = r | (64'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_blank(input longint v, input int digits);
    logic [63:0] r;
    longint p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    v = v % p;
    p = 10;
    for (int i = 1; i < digits; i++) begin
      if (v < p) r[i] = 1'b1;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic getDone(input int which);
    case (which)
      0:       return bus_a.done;
      1:       return bus_b.done;
      default: return bus_c.done;
    endcase
  endfunction

  function automatic logic getBusy(input int which);
    case (which)
      0:       return bus_a.busy;
      1:       return bus_b.busy;
      default: return bus_c.busy;
    endcase
  endfunction

  // Called at a negedge: start is high for exactly one rising edge.
  task automatic applyStimulus(input int which, input int value);
    case (which)
      0: begin bus_a.bin = 8'(value);  bus_a.start = 1'b1; end
      1: begin bus_b.bin = 4'(value);  bus_b.start = 1'b1; end
      default: begin bus_c.bin = 10'(value); bus_c.start = 1'b1; end
    endcase
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
  endtask

  task automatic waitDone(input int which, input int budget, output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (!getDone(which) && cycles < budget) begin
      if (getBusy(which)) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    if (!getDone(which)) cycles = -1;
  endtask

  task automatic countDones(input int which, input int span, output int n);
    n = 0;
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (getDone(which)) n++;
    end
  endtask

  // Model of the 8-bit instance, driven purely by the documented timing:
  // done arrives BIN_W+1 edges after acceptance, busy covers the edges between.
  bit          m_active;
  int          m_phase;
  int          m_val;
  logic [11:0] m_bcd;
  logic [2:0]  m_blank;
  logic        m_busy;
  logic        m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0;
      m_phase  = 0;
      m_bcd    = '0;
      m_blank  = '0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        m_busy = 1'b0;
        if (bus_a.start === 1'b1) begin
          m_active = 1;
          m_phase  = 0;
          m_val    = int'(bus_a.bin);
        end
      end else begin
        m_phase++;
        if (m_phase <= 8) begin
          m_busy = 1'b1;
        end else begin
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_bcd    = 12'(ref_bcd(m_val, 3));
          m_blank  = 3'(ref_blank(m_val, 3));
          m_active = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_busy", bus_a.busy, m_busy);
      checkOutput("model_done", bus_a.done, m_done);
      checkOutput("model_bcd",  bus_a.bcd,  m_bcd);
`ifdef BIN_BCD_SEQ_LZB_EN
      checkOutput("model_blank", bus_a.blank, m_blank);
`endif
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int bsy;
    int n;
    int seen;
    int guard;

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.bin = '0;
    bus_b.start = 1'b0; bus_b.bin = '0;
    bus_c.start = 1'b0; bus_c.bin = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1;

    checkOutput("reset_bcd",  bus_a.bcd,  12'h000);
    checkOutput("reset_busy", bus_a.busy, 1'b0);
    checkOutput("reset_done", bus_a.done, 1'b0);
    countDones(0, 6, n);
    checkOutput("idle_no_done", n, 0);

    applyStimulus(0, 255);
    waitDone(0, 30, cyc, bsy);
    checkOutput("lat_255",  cyc, 9);
    checkOutput("busy_255", bsy, 8);
    checkOutput("bcd_255",  bus_a.bcd, 12'h255);
    @(negedge clk);
    checkOutput("done_single", bus_a.done, 1'b0);

    applyStimulus(0, 0);
    waitDone(0, 30, cyc, bsy);
    checkOutput("bcd_0", bus_a.bcd, 12'h000);
    @(negedge clk);

    applyStimulus(0, 99);
    waitDone(0, 30, cyc, bsy);
    checkOutput("bcd_99", bus_a.bcd, 12'h099);
    @(negedge clk);

    // A start while busy must be dropped, not queued.
    applyStimulus(0, 128);
    repeat (3) @(negedge clk);
    applyStimulus(0, 7);
    waitDone(0, 30, cyc, bsy);
    checkOutput("busy_ignore_found", cyc >= 0, 1'b1);
    checkOutput("bcd_128", bus_a.bcd, 12'h128);
    countDones(0, 15, n);
    checkOutput("no_queued_done", n, 0);
    checkOutput("bcd_128_hold", bus_a.bcd, 12'h128);

    applyStimulus(0, 42);
    waitDone(0, 30, cyc, bsy);
    checkOutput("bcd_42", bus_a.bcd, 12'h042);
`ifdef BIN_BCD_SEQ_LZB_EN
    checkOutput("blank_42", bus_a.blank, 3'b100);
`endif
    applyStimulus(0, 7);
    waitDone(0, 30, cyc, bsy);
    checkOutput("b2b_gap", cyc + 1, 10);
    checkOutput("bcd_7", bus_a.bcd, 12'h007);
    @(negedge clk);

    // Reset lands on the rising edge after the 4th observed busy cycle.
    applyStimulus(0, 200);
    seen  = 0;
    guard = 0;
    while (seen < 4 && guard < 30) begin
      @(negedge clk);
      guard++;
      if (bus_a.busy) seen++;
    end
    checkOutput("mid_busy_seen", seen, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", bus_a.busy, 1'b0);
    checkOutput("abort_done", bus_a.done, 1'b0);
    checkOutput("abort_bcd",  bus_a.bcd,  12'h000);
    countDones(0, 12, n);
    checkOutput("abort_no_done", n, 0);
    applyStimulus(0, 200);
    waitDone(0, 30, cyc, bsy);
    checkOutput("bcd_200", bus_a.bcd, 12'h200);
    @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      applyStimulus(1, v);
      waitDone(1, 20, cyc, bsy);
      checkOutput("legacy_lat", cyc, 5);
      checkOutput("legacy_bcd", bus_b.bcd, ref_bcd(v, 2));
      if (v == 10) checkOutput("legacy_10", bus_b.bcd, 8'h10);
      if (v == 15) checkOutput("legacy_15", bus_b.bcd, 8'h15);
      @(negedge clk);
    end

    for (int v = 0; v < 1024; v++) begin
      applyStimulus(2, v);
      waitDone(2, 30, cyc, bsy);
      checkOutput("wide_lat", cyc, 11);
      checkOutput("wide_bcd", bus_c.bcd, ref_bcd(v, 4));
`ifdef BIN_BCD_SEQ_LZB_EN
      checkOutput("wide_blank", bus_c.blank, ref_blank(v, 4));
      if (v == 5)    checkOutput("blank_5",    bus_c.blank, 4'b1110);
      if (v == 1000) checkOutput("blank_1000", bus_c.blank, 4'b0000);
`endif
      if (v == 1023) checkOutput("wide_1023", bus_c.bcd, 16'h1023);
      @(negedge clk);
    end

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
